frame_responder: RTL and testbench

Peer endpoint of the byte-stuffed serial frame link, on the other side from the FPGA frame interface. It consumes the de-serialised byte stream, detects the frame start byte, removes the escape stuffing and reassembles one fixed-length frame. It then returns a single confirmation byte (OKAY, ERROR or FATAL_ERROR) through a valid/ready byte port. It is used as a hardware loopback partner and as the host model in system benches, and sits between RS232_RECEIVER/RS232_TRANSMITTER byte ports and test logic.

---
 rtl/frame_responder_if.sv | 19 +
 rtl/frame_responder.sv | 146 ++++++++++++++
 tb/tb_frame_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_responder_if.sv
// Byte link between the frame responder and its serial byte ports / test logic.
// rx_valid is a one-cycle strobe with no back-pressure; tx_byte/tx_valid hold until a cycle with tx_ready=1.
interface frame_responder_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_byte, rx_valid, tx_ready,
    input  tx_byte, tx_valid
  );

  modport slave (
    input  rx_byte, rx_valid, tx_ready,
    output tx_byte, tx_valid
  );
endinterface

// File: rtl/frame_responder.sv
// Receives a byte-stuffed frame, de-stuffs it into a shadow buffer and answers
// with one confirmation byte (OKAY / ERROR / FATAL_ERROR).
module frame_responder #(
  parameter int DATA_SIZE     = 64,
  parameter int PREAMBLE_SIZE = 7,
  parameter int CRC_SIZE      = 4,
  parameter int FRAME_BYTES   = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE,
  parameter int MAX_ERRORS    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  frame_responder_if.slave           link,
  output logic [0:FRAME_BYTES*8-1]   fout,
  output logic                       fout_valid,
  output logic [7:0]                 frame_type,
  output logic [7:0]                 err_count,
  output logic                       fatal,
  output logic [2:0]                 dbg_state
);

  localparam logic [7:0] FRAME_START = 8'h06;
  localparam logic [7:0] FRAME_END   = 8'h07;
  localparam logic [7:0] ESC_VAL     = 8'h14;
  localparam logic [7:0] ESC_XOR     = 8'h20;
  localparam logic [7:0] OKAY        = 8'h05;
  localparam logic [7:0] ERROR       = 8'h04;
  localparam logic [7:0] FATAL_ERROR = 8'h08;

  localparam int CNT_W = $clog2(FRAME_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BYTES + 1);
  localparam logic [7:0]       MAX_ERR  = 8'(MAX_ERRORS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    ESC   = 3'd2,
    CHECK = 3'd3,
    SEND  = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t                  state, next_state;
  logic [CNT_W-1:0]        cnt;
  logic [0:FRAME_BYTES*8-1] shadow;
  logic                    rx_start;
  logic                    store_en;
  logic [7:0]              store_byte;
  logic                    frame_good;
  logic [7:0]              err_next;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // In ESC the byte is data regardless of value; flags only act in RECV/IDLE.
  always_comb begin
    next_state = state;
    rx_start   = 1'b0;
    store_en   = 1'b0;
    store_byte = link.rx_byte;
    case (state)
      IDLE: begin
        if (link.rx_valid && link.rx_byte == FRAME_START) begin
          rx_start   = 1'b1;
          next_state = RECV;
        end
      end
      RECV: begin
        if (link.rx_valid) begin
          if (link.rx_byte == ESC_VAL)          next_state = ESC;
          else if (link.rx_byte == FRAME_END)   next_state = CHECK;
          else if (link.rx_byte == FRAME_START) rx_start   = 1'b1;
          else                                  store_en   = 1'b1;
        end
      end
      ESC: begin
        if (link.rx_valid) begin
          store_en   = 1'b1;
          store_byte = link.rx_byte ^ ESC_XOR;
          next_state = RECV;
        end
      end
      CHECK: next_state = SEND;
      SEND: begin
        if (link.tx_ready) next_state = fatal ? HALT : IDLE;
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  assign frame_good = (cnt == CNT_FULL) && (shadow[0:7] <= 8'h03);
  assign err_next   = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      shadow        <= '0;
      fout          <= '0;
      fout_valid    <= 1'b0;
      frame_type    <= 8'h00;
      err_count     <= 8'h00;
      fatal         <= 1'b0;
      link.tx_byte  <= 8'h00;
      link.tx_valid <= 1'b0;
    end else begin
      fout_valid <= 1'b0;

      // Bytes past the frame length are counted (so over-long frames fail) but not stored.
      if (rx_start) begin
        cnt <= '0;
      end else if (store_en) begin
        for (int k = 0; k < FRAME_BYTES; k++) begin
          if (cnt == CNT_W'(k)) shadow[k*8 +: 8] <= store_byte;
        end
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end

      if (state == CHECK) begin
        link.tx_valid <= 1'b1;
        if (frame_good) begin
          fout         <= shadow;
          frame_type   <= shadow[0:7];
          fout_valid   <= 1'b1;
          err_count    <= 8'h00;
          link.tx_byte <= OKAY;
        end else begin
          err_count <= err_next;
          if (err_next >= MAX_ERR) begin
            link.tx_byte <= FATAL_ERROR;
            fatal        <= 1'b1;
          end else begin
            link.tx_byte <= ERROR;
          end
        end
      end

      if (state == SEND && link.tx_ready) link.tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_responder.sv
// Directed bench for frame_responder: good, stuffed, bad, resync, back-pressure,
// async reset and fatal-halt scenarios with hand-computed expectations.
module tb_frame_responder;

  localparam int FB = 75;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RECV = 3'd1;
  localparam logic [2:0] ST_HALT = 3'd5;

  logic              clk;
  logic              rst;
  logic [0:FB*8-1]   fout;
  logic              fout_valid;
  logic [7:0]        frame_type;
  logic [7:0]        err_count;
  logic              fatal;
  logic [2:0]        dbg_state;

  frame_responder_if link_if ();

  frame_responder dut (
    .clk        (clk),
    .rst        (rst),
    .link       (link_if.slave),
    .fout       (fout),
    .fout_valid (fout_valid),
    .frame_type (frame_type),
    .err_count  (err_count),
    .fatal      (fatal),
    .dbg_state  (dbg_state)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [7:0]      pay_q[$];
  logic [0:FB*8-1] exp_fout;
  logic [0:FB*8-1] prev_fout;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    link_if.rx_byte  = b;
    link_if.rx_valid = 1'b1;
  endtask

  task automatic end_rx();
    @(negedge clk);
    link_if.rx_valid = 1'b0;
  endtask

  task automatic make_frame(input logic [7:0] t, input int len);
    pay_q.delete();
    pay_q.push_back(t);
    for (int k = 1; k < len; k++) pay_q.push_back(k[7:0]);
  endtask

  task automatic build_exp();
    exp_fout = '0;
    for (int k = 0; k < FB; k++) exp_fout[k*8 +: 8] = pay_q[k];
  endtask

  // Returns with the DUT in CHECK (between the edge sampling 0x07 and the response edge).
  task automatic send_frame();
    send_byte(8'h06);
    foreach (pay_q[i]) begin
      if (pay_q[i] == 8'h06 || pay_q[i] == 8'h07 || pay_q[i] == 8'h14) begin
        send_byte(8'h14);
        send_byte(pay_q[i] ^ 8'h20);
      end else begin
        send_byte(pay_q[i]);
      end
    end
    send_byte(8'h07);
    end_rx();
  endtask

  task automatic get_confirm(output logic [7:0] b, output bit got);
    got = 1'b0;
    b   = 8'h00;
    for (int i = 0; i < 100 && !got; i++) begin
      if (link_if.tx_valid) begin
        got = 1'b1;
        b   = link_if.tx_byte;
      end else begin
        @(negedge clk);
      end
    end
    if (got) begin
      link_if.tx_ready = 1'b1;
      @(negedge clk);
      link_if.tx_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    link_if.rx_byte  = 8'h00;
    link_if.rx_valid = 1'b0;
    link_if.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (link_if.tx_valid !== 1'b0 || link_if.tx_byte !== 8'h00) begin
      miss_cnt++;
      $display("FAIL reset_tx: actual valid=%b byte=%h required valid=0 byte=00", link_if.tx_valid, link_if.tx_byte);
    end
    vec_cnt++;
    if (fout !== '0 || fout_valid !== 1'b0 || frame_type !== 8'h00) begin
      miss_cnt++;
      $display("FAIL reset_fout: actual fout_valid=%b type=%h fout_zero=%b required 0/00/1", fout_valid, frame_type, fout == '0);
    end
    vec_cnt++;
    if (err_count !== 8'h00 || fatal !== 1'b0 || dbg_state !== ST_IDLE) begin
      miss_cnt++;
      $display("FAIL reset_status: actual err=%0d fatal=%b state=%0d required 0/0/0", err_count, fatal, dbg_state);
    end
  endtask

  task automatic test_good_frame();
    make_frame(8'h02, FB);
    build_exp();
    send_frame();
    @(negedge clk);
    vec_cnt++;
    if (fout_valid !== 1'b1 || link_if.tx_valid !== 1'b1 || link_if.tx_byte !== 8'h05) begin
      miss_cnt++;
      $display("FAIL good_response_timing: actual fv=%b tv=%b tb=%h required 1/1/05", fout_valid, link_if.tx_valid, link_if.tx_byte);
    end
    vec_cnt++;
    if (fout !== exp_fout || frame_type !== 8'h02 || err_count !== 8'h00) begin
      miss_cnt++;
      $display("FAIL good_contents: actual byte0=%h byte74=%h type=%h err=%0d required 02/4a/02/0", fout[0:7], fout[74*8 +: 8], frame_type, err_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (fout_valid !== 1'b0 || link_if.tx_valid !== 1'b1 || link_if.tx_byte !== 8'h05) begin
        miss_cnt++;
        $display("FAIL good_hold cycle %0d: actual fv=%b tv=%b tb=%h required 0/1/05", i, fout_valid, link_if.tx_valid, link_if.tx_byte);
      end
    end
    link_if.tx_ready = 1'b1;
    @(negedge clk);
    link_if.tx_ready = 1'b0;
    vec_cnt++;
    if (link_if.tx_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      miss_cnt++;
      $display("FAIL good_handshake: actual tv=%b state=%0d required 0/0", link_if.tx_valid, dbg_state);
    end
  endtask

  task automatic test_stuffing();
    logic [7:0] b;
    bit got;
    make_frame(8'h01, FB);
    pay_q[10] = 8'h06;
    pay_q[11] = 8'h07;
    pay_q[12] = 8'h14;
    pay_q[13] = 8'h26;
    pay_q[74] = 8'h14;
    build_exp();
    send_frame();
    get_confirm(b, got);
    vec_cnt++;
    if (!got || b !== 8'h05) begin
      miss_cnt++;
      $display("FAIL stuff_confirm: actual got=%b byte=%h required 1/05", got, b);
    end
    vec_cnt++;
    if (fout !== exp_fout || frame_type !== 8'h01) begin
      miss_cnt++;
      $display("FAIL stuff_contents: actual b10..13=%h%h%h%h type=%h required 06071426/01", fout[80 +: 8], fout[88 +: 8], fout[96 +: 8], fout[104 +: 8], frame_type);
    end
  endtask

  task automatic test_recovery();
    logic [7:0] b;
    bit got;
    prev_fout = exp_fout;
    make_frame(8'h00, FB - 1);
    send_frame();
    get_confirm(b, got);
    vec_cnt++;
    if (!got || b !== 8'h04 || err_count !== 8'd1 || fout !== prev_fout || frame_type !== 8'h01) begin
      miss_cnt++;
      $display("FAIL short_frame: actual got=%b byte=%h err=%0d fout_same=%b type=%h required 1/04/1/1/01", got, b, err_count, fout == prev_fout, frame_type);
    end
    make_frame(8'h00, 80);
    send_frame();
    get_confirm(b, got);
    vec_cnt++;
    if (!got || b !== 8'h04 || err_count !== 8'd2 || fout !== prev_fout) begin
      miss_cnt++;
      $display("FAIL long_frame: actual got=%b byte=%h err=%0d fout_same=%b required 1/04/2/1", got, b, err_count, fout == prev_fout);
    end
    make_frame(8'h03, FB);
    build_exp();
    send_frame();
    get_confirm(b, got);
    vec_cnt++;
    if (!got || b !== 8'h05 || err_count !== 8'd0 || fout !== exp_fout || frame_type !== 8'h03) begin
      miss_cnt++;
      $display("FAIL recovery_good: actual got=%b byte=%h err=%0d type=%h required 1/05/0/03", got, b, err_count, frame_type);
    end
  endtask

  task automatic test_resync_backpressure();
    logic [7:0] b;
    bit got;
    bit seen;
    send_byte(8'h06);
    for (int i = 0; i < 20; i++) send_byte(8'hA0 + i[7:0]);
    make_frame(8'h00, FB);
    pay_q[5] = 8'h55;
    build_exp();
    send_frame();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      send_byte((i == 0) ? 8'h06 : 8'h30 + i[7:0]);
      vec_cnt++;
      if (link_if.tx_valid !== 1'b1 || link_if.tx_byte !== 8'h05) begin
        miss_cnt++;
        $display("FAIL backpressure_hold cycle %0d: actual tv=%b tb=%h required 1/05", i, link_if.tx_valid, link_if.tx_byte);
      end
    end
    link_if.rx_valid = 1'b0;
    get_confirm(b, got);
    vec_cnt++;
    if (!got || b !== 8'h05 || fout !== exp_fout) begin
      miss_cnt++;
      $display("FAIL resync_confirm: actual got=%b byte=%h byte5=%h required 1/05/55", got, b, fout[40 +: 8]);
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (link_if.tx_valid || dbg_state != ST_IDLE) seen = 1'b1;
    end
    vec_cnt++;
    if (seen !== 1'b0) begin
      miss_cnt++;
      $display("FAIL resync_single_response: actual extra_activity=%b required 0", seen);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] b;
    bit got;
    send_byte(8'h06);
    for (int i = 0; i < 10; i++) send_byte(8'h40 + i[7:0]);
    vec_cnt++;
    if (dbg_state !== ST_RECV) begin
      miss_cnt++;
      $display("FAIL pre_reset_recv: actual state=%0d required 1", dbg_state);
    end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if (fout !== '0 || frame_type !== 8'h00 || dbg_state !== ST_IDLE || link_if.tx_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset_mid_recv: actual fout_zero=%b type=%h state=%0d tv=%b required 1/00/0/0", fout == '0, frame_type, dbg_state, link_if.tx_valid);
    end
    link_if.rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    make_frame(8'h01, FB);
    send_frame();
    @(negedge clk);
    vec_cnt++;
    if (link_if.tx_valid !== 1'b1 || link_if.tx_byte !== 8'h05) begin
      miss_cnt++;
      $display("FAIL pre_reset_send: actual tv=%b tb=%h required 1/05", link_if.tx_valid, link_if.tx_byte);
    end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if (link_if.tx_valid !== 1'b0 || link_if.tx_byte !== 8'h00 || fout !== '0 || fout_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset_mid_send: actual tv=%b tb=%h fout_zero=%b fv=%b required 0/00/1/0", link_if.tx_valid, link_if.tx_byte, fout == '0, fout_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    make_frame(8'h02, FB);
    pay_q[20] = 8'h07;
    build_exp();
    send_frame();
    get_confirm(b, got);
    vec_cnt++;
    if (!got || b !== 8'h05 || fout !== exp_fout) begin
      miss_cnt++;
      $display("FAIL after_reset_frame: actual got=%b byte=%h byte20=%h required 1/05/07", got, b, fout[160 +: 8]);
    end
  endtask

  task automatic test_fatal();
    logic [7:0] b;
    bit got;
    bit seen;
    prev_fout = exp_fout;
    make_frame(8'h00, FB - 1);
    send_frame();
    get_confirm(b, got);
    vec_cnt++;
    if (!got || b !== 8'h04 || err_count !== 8'd1 || fatal !== 1'b0) begin
      miss_cnt++;
      $display("FAIL fatal_step1: actual got=%b byte=%h err=%0d fatal=%b required 1/04/1/0", got, b, err_count, fatal);
    end
    make_frame(8'h00, 80);
    send_frame();
    get_confirm(b, got);
    vec_cnt++;
    if (!got || b !== 8'h04 || err_count !== 8'd2 || fatal !== 1'b0) begin
      miss_cnt++;
      $display("FAIL fatal_step2: actual got=%b byte=%h err=%0d fatal=%b required 1/04/2/0", got, b, err_count, fatal);
    end
    make_frame(8'h09, FB);
    send_frame();
    get_confirm(b, got);
    vec_cnt++;
    if (!got || b !== 8'h08 || err_count !== 8'd3 || fatal !== 1'b1 || dbg_state !== ST_HALT || fout !== prev_fout) begin
      miss_cnt++;
      $display("FAIL fatal_step3: actual got=%b byte=%h err=%0d fatal=%b state=%0d required 1/08/3/1/5", got, b, err_count, fatal, dbg_state);
    end
    make_frame(8'h00, FB);
    send_frame();
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (link_if.tx_valid || fout_valid) seen = 1'b1;
    end
    vec_cnt++;
    if (seen !== 1'b0 || dbg_state !== ST_HALT || fout !== prev_fout) begin
      miss_cnt++;
      $display("FAIL halt_ignores_rx: actual activity=%b state=%0d fout_same=%b required 0/5/1", seen, dbg_state, fout == prev_fout);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_stuffing();
    test_recovery();
    test_resync_backpressure();
    test_async_reset();
    test_fatal();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
